// File: rtl/missile_launch_arbiter.sv
// missile_launch_arbiter: frame-synchronous round-robin launch arbiter for three projectile slots
module missile_launch_arbiter #(
  parameter logic [3:0] COOLDOWN_FRAMES = 4'd8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       shoot,
  input  logic       enable,
  input  logic [2:0] missile_active,
  output logic [2:0] fire,
  output logic [1:0] missile_select,
  output logic       ready,
  output logic [7:0] shots_fired
);
  typedef enum logic [1:0] {IDLE, FIRE, COOLDOWN} state_e;
  state_e     state_q;
  logic       frame_clk_q, shoot_q, pending_q, pending_d;
  logic       frame_tick, shoot_edge, grant;
  logic [1:0] ptr_q, ptr_d, s1, s2, slot;
  logic [3:0] cnt_q;
  assign frame_tick = frame_clk & ~frame_clk_q;
  assign shoot_edge = shoot & ~shoot_q;
  assign grant      = (state_q == IDLE) & frame_tick & enable & (pending_q | shoot_edge) & ~&missile_active;
  assign pending_d  = enable & ~grant & (pending_q | shoot_edge);
  assign ready      = (state_q == IDLE) & ~&missile_active & enable;
  // Round-robin candidates ptr, ptr+1, ptr+2 in mod-3 arithmetic
  always_comb begin
    s1    = (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;
    s2    = (ptr_q == 2'd0) ? 2'd2 : ptr_q - 2'd1;
    slot  = ~missile_active[ptr_q] ? ptr_q : ~missile_active[s1] ? s1 : s2;
    ptr_d = (slot == 2'd2) ? 2'd0 : slot + 2'd1;
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q        <= IDLE;
      frame_clk_q    <= 1'b0;
      shoot_q        <= 1'b0;
      pending_q      <= 1'b0;
      ptr_q          <= 2'd0;
      cnt_q          <= 4'd0;
      fire           <= 3'b000;
      missile_select <= 2'd0;
      shots_fired    <= 8'd0;
    end else begin
      frame_clk_q <= frame_clk;
      shoot_q     <= shoot;
      pending_q   <= pending_d;
      if (!enable) begin
        state_q <= IDLE;
        fire    <= 3'b000;
      end else begin
        case (state_q)
          IDLE: if (grant) begin
            state_q        <= FIRE;
            fire           <= 3'b001 << slot;
            missile_select <= slot;
            ptr_q          <= ptr_d;
            shots_fired    <= shots_fired + 8'd1;
          end
          FIRE: if (frame_tick) begin
            fire    <= 3'b000;
            state_q <= (COOLDOWN_FRAMES == 4'd0) ? IDLE : COOLDOWN;
            cnt_q   <= COOLDOWN_FRAMES;
          end
          COOLDOWN: if (frame_tick) begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_missile_launch_arbiter.sv
// tb_missile_launch_arbiter: randomized and directed stimulus against a frame-lockout reference model,
// with a scoreboard of expected launches consumed by an independent monitor.
module tb_missile_launch_arbiter;
  localparam logic [3:0] CD = 4'd8;
  logic       Clk = 1'b0, Reset = 1'b1, frame_clk = 1'b0, shoot = 1'b0, enable = 1'b1;
  logic [2:0] missile_active = 3'b000;
  logic [2:0] fire;
  logic [1:0] missile_select;
  logic       ready;
  logic [7:0] shots_fired;

  missile_launch_arbiter #(.COOLDOWN_FRAMES(CD)) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .shoot(shoot), .enable(enable),
    .missile_active(missile_active), .fire(fire), .missile_select(missile_select),
    .ready(ready), .shots_fired(shots_fired)
  );

  always #5 Clk = ~Clk;

  // Reference model: lock counts frame ticks until grants are allowed again
  int         lock, m_ptr;
  bit         pend, fprev, sprev;
  logic [2:0] m_fire;
  logic [1:0] m_sel;
  logic [7:0] m_shots;
  logic [10:0] exp_q[$];

  always @(posedge Clk or posedge Reset) begin : model
    bit ft, se, g;
    int sl;
    if (Reset) begin
      lock = 0; pend = 0; m_ptr = 0; m_fire = 0; m_sel = 0; m_shots = 0; fprev = 0; sprev = 0;
    end else begin
      ft = frame_clk && !fprev;
      se = shoot && !sprev;
      fprev = frame_clk;
      sprev = shoot;
      if (!enable) begin
        lock = 0; pend = 0; m_fire = 0;
      end else begin
        g = (lock == 0) && ft && (pend || se) && (missile_active != 3'b111);
        if (g) begin
          sl = -1;
          for (int k = 0; k < 3; k++)
            if (sl < 0 && !missile_active[(m_ptr + k) % 3]) sl = (m_ptr + k) % 3;
          m_fire  = 3'(1 << sl);
          m_sel   = 2'(sl);
          m_shots = m_shots + 8'd1;
          m_ptr   = (sl + 1) % 3;
          lock    = 1 + int'(CD);
          pend    = 0;
          exp_q.push_back({m_fire, m_shots});
        end else begin
          if (se) pend = 1;
          if (ft && lock > 0) begin
            lock = lock - 1;
            m_fire = 0;
          end
        end
      end
    end
  end

  int         checks = 0, errors = 0, rd = 0;
  bit         mon_en = 0, done = 0, fin = 0;
  logic [2:0] prev_fire = 3'b000;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  always begin : monitor
    @(negedge Clk or posedge Reset);
    #1;
    if (mon_en) begin
      if (Clk) begin
        chk("async_fire", int'(fire), 0);
        chk("async_sel", int'(missile_select), 0);
        chk("async_shots", int'(shots_fired), 0);
      end else begin
        chk("fire", int'(fire), int'(m_fire));
        chk("sel", int'(missile_select), int'(m_sel));
        chk("shots", int'(shots_fired), int'(m_shots));
        chk("ready", int'(ready), int'(lock == 0 && enable && missile_active != 3'b111));
        if (fire != 3'b000 && prev_fire == 3'b000) begin
          if (rd < exp_q.size()) begin
            chk("sb_fire", int'(fire), int'(exp_q[rd][10:8]));
            chk("sb_shots", int'(shots_fired), int'(exp_q[rd][7:0]));
            rd++;
          end else chk("sb_unexpected_fire", int'(fire), 0);
        end
        if (done && !fin) begin
          chk("sb_drained", rd, exp_q.size());
          fin = 1;
        end
      end
      prev_fire = fire;
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge Clk);
  endtask
  task automatic frame(int hi = 2, int lo = 4);
    frame_clk = 1'b1; cyc(hi);
    frame_clk = 1'b0; cyc(lo);
  endtask
  task automatic frames(int n);
    repeat (n) frame();
  endtask
  task automatic press();
    shoot = 1'b1; cyc(2);
    shoot = 1'b0; cyc(1);
  endtask

  initial begin
    cyc(3);
    Reset = 1'b0;
    mon_en = 1;
    press(); frames(10);
    repeat (4) begin press(); frames(10); end
    missile_active = 3'b111; press(); frames(3);
    missile_active = 3'b101; frames(11);
    missile_active = 3'b000;
    shoot = 1'b1; frames(50); shoot = 1'b0; frames(2);
    press(); frame(); cyc(2);
    enable = 1'b0; cyc(2); enable = 1'b1; frames(12);
    enable = 1'b0; press(); enable = 1'b1; frames(3);
    repeat (2000) begin
      frame_clk      = ($urandom_range(0, 3) == 0);
      shoot          = ($urandom_range(0, 3) == 0);
      enable         = ($urandom_range(0, 31) != 0);
      missile_active = 3'($urandom);
      cyc(1);
    end
    frame_clk = 1'b0; shoot = 1'b0; enable = 1'b1; missile_active = 3'b000;
    frames(12);
    repeat (256) begin press(); repeat (10) frame(1, 1); end
    press(); frame(); frame(); frame();
    @(posedge Clk); #2 Reset = 1'b1;
    cyc(2); Reset = 1'b0;
    press(); frames(3);
    done = 1;
    cyc(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
